// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage carrying NF fields of W bits.
// It uses a valid/ready handshake. With SKID=1 a second (skid) entry lets in_ready
// depend only on state, so stalls do not ripple combinationally upstream.
// flush clears the stage. Fields marked in KEEP_MASK keep their value so that
// state such as a PC can still be captured after an exception.
//
// Ports:
//   clk        rising-edge clock
//   reset      async active-low reset
//   flush      synchronous stage clear, has priority over all transfers
//   in_valid   upstream offers a beat
//   in_ready   stage accepts a beat this cycle
//   in_data    NF*W upstream fields, field k = in_data[k*W +: W]
//   out_valid  main entry holds a beat
//   out_ready  downstream accepts this cycle
//   out_data   main entry fields
//   occupancy  entries held (0..2)

// Per-field storage: a main register and a skid register.
module pipe_stage_field #(
  parameter int W    = 32,
  parameter bit KEEP = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         ld_in,    // main <= d
  input  logic         ld_mv,    // main <= skid
  input  logic         ld_skid,  // skid <= d
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] skid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Kept fields hold, so that the PC of the flushed beat is still readable.
      if (!KEEP) q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_in)      q <= d;
      else if (ld_mv) q <= skid_q;
      if (ld_skid) skid_q <= d;
    end
  end
endmodule

module pipe_stage_reg #(
  parameter int            W         = 32,
  parameter int            NF        = 4,
  parameter logic [NF-1:0] KEEP_MASK = NF'(4'b0010),
  parameter int            SKID      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NF*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NF*W-1:0] out_data,
  output logic [1:0]      occupancy
);
  // The encoding is {main_v, skid_v}, so the valid bits come straight off the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b10,
    FULL2 = 2'b11
  } state_t;

  state_t                 state, state_n;
  logic                   main_v, skid_v;
  logic                   acc, dep;
  logic                   ld_in, ld_mv, ld_skid;
  logic [NF-1:0][W-1:0]   in_f, out_f;

  assign {main_v, skid_v} = state;
  assign in_f      = in_data;
  assign out_data  = out_f;
  assign out_valid = main_v;

  generate
    if (SKID != 0) begin : g_skid
      // in_ready depends only on the skid flop, so it does not form a ready chain.
      assign in_ready = reset & ~flush & ~skid_v;
    end else begin : g_noskid
      assign in_ready = reset & ~flush & (~main_v | out_ready);
    end
  endgenerate

  assign acc = in_valid & in_ready;
  assign dep = main_v & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      occupancy <= 2'd0;
    end else begin
      state     <= state_n;
      occupancy <= 2'(state_n[1]) + 2'(state_n[0]);
    end
  end

  always_comb begin
    state_n = state;
    ld_in   = 1'b0;
    ld_mv   = 1'b0;
    ld_skid = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          state_n = FULL1;
          ld_in   = 1'b1;
        end
        FULL1: begin
          if (acc && dep) begin
            ld_in = 1'b1;
          end else if (acc && SKID != 0) begin
            // Main is stalled, so the new beat waits behind it in the skid entry.
            state_n = FULL2;
            ld_skid = 1'b1;
          end else if (dep) begin
            state_n = EMPTY;
          end
        end
        FULL2: if (dep) begin
          state_n = FULL1;
          ld_mv   = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  for (genvar k = 0; k < NF; k++) begin : g_field
    pipe_stage_field #(.W(W), .KEEP(KEEP_MASK[k])) u_field (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .ld_in   (ld_in),
      .ld_mv   (ld_mv),
      .ld_skid (ld_skid),
      .d       (in_f[k]),
      .q       (out_f[k])
    );
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance 0 uses SKID=0 and instance 1 uses SKID=1.
// The reference model treats each stage as a bounded FIFO (capacity 1 or 2) plus a
// held "last main" value. It is checked every negedge. Directed literal checks pin
// the model itself.
module tb_pipe_stage_reg;
  localparam int          W    = 32;
  localparam int          NF   = 4;
  localparam int          DW   = NF * W;
  localparam logic [3:0]  KEEP = 4'b0010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         iv = '0, ordy = '0, fl = '0;
  logic [1:0][DW-1:0] id = '0;
  logic               rdy0, rdy1, ov0, ov1;
  logic [DW-1:0]      od0, od1;
  logic [1:0]         oc0, oc1;
  logic [1:0]         rdy, ov;
  logic [1:0][DW-1:0] od;
  logic [1:0][1:0]    occ;
  assign rdy = {rdy1, rdy0};
  assign ov  = {ov1, ov0};
  assign od  = {od1, od0};
  assign occ = {oc1, oc0};

  pipe_stage_reg #(.W(W), .NF(NF), .KEEP_MASK(KEEP), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(rdy0),
    .in_data(id[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0), .occupancy(oc0));
  pipe_stage_reg #(.W(W), .NF(NF), .KEEP_MASK(KEEP), .SKID(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(rdy1),
    .in_data(id[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1), .occupancy(oc1));

  int errs = 0, checks = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---- reference model: a FIFO of accepted beats (front = main entry) ----
  logic [DW-1:0] mq [2][2];
  logic [DW-1:0] mmain [2] = '{default: '0};
  int            mcnt [2] = '{0, 0};

  function automatic bit exp_rdy(int k);
    if (!reset || fl[k]) return 1'b0;
    if (k == 1) return mcnt[1] < 2;
    return mcnt[0] == 0 || ordy[0];
  endfunction

  always begin
    bit a, d;
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k]  = 0;
        mmain[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        a = iv[k] && exp_rdy(k);
        d = (mcnt[k] > 0) && ordy[k];
        if (fl[k]) begin
          mcnt[k] = 0;
          for (int f = 0; f < NF; f++)
            if (!KEEP[f]) mmain[k][f*W +: W] = '0;
        end else begin
          if (d) begin
            mq[k][0] = mq[k][1];
            mcnt[k]--;
          end
          if (a) begin
            mq[k][mcnt[k]] = id[k];
            mcnt[k]++;
          end
          if (mcnt[k] > 0) mmain[k] = mq[k][0];
        end
      end
    end
  end

  // ---- per-cycle compare ----
  always begin
    @(negedge clk);
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("in_ready[%0d]", k),  DW'(rdy[k]), DW'(exp_rdy(k)));
        chk($sformatf("out_valid[%0d]", k), DW'(ov[k]),  DW'(mcnt[k] > 0));
        chk($sformatf("out_data[%0d]", k),  od[k],       mmain[k]);
        chk($sformatf("occupancy[%0d]", k), DW'(occ[k]), DW'(mcnt[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] A = 128'hA;
  localparam logic [DW-1:0] B = 128'hB;
  localparam logic [DW-1:0] P = {32'h3333, 32'h2222, 32'h0000_1008, 32'h0000_DEAD};
  localparam logic [DW-1:0] C = 128'hC0FFEE;

  initial begin
    #1 reset = 1'b0;
    run = 1'b1;
    repeat (3) cyc();
    chk("rst in_ready", DW'(rdy1), '0);
    chk("rst out_valid", DW'(ov1), '0);
    chk("rst occupancy", DW'(oc1), '0);
    chk("rst out_data", od1, '0);
    reset = 1'b1;
    #1 chk("release in_ready", DW'(rdy1), 1);

    // Streaming at full rate with no bubbles.
    ordy[1] = 1'b1;
    iv[1]   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id[1] = DW'(32'h11 * (i + 1));
      cyc();
      chk("stream data", DW'(od1[31:0]), DW'(32'h11 * (i + 1)));
      chk("stream occ", DW'(oc1), 1);
    end
    iv[1] = 1'b0;
    cyc();
    chk("stream drained", DW'(ov1), '0);

    // Fill both entries while stalled, then drain in order.
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = A; cyc();
    id[1] = B; cyc();
    iv[1] = 1'b0;
    chk("full occ", DW'(oc1), 2);
    chk("full in_ready", DW'(rdy1), '0);
    chk("full data A", od1, A);
    cyc();
    chk("stall data A", od1, A);
    ordy[1] = 1'b1; cyc();
    chk("drain data B", od1, B);
    chk("drain in_ready", DW'(rdy1), 1);
    cyc();
    chk("drain occ", DW'(oc1), '0);

    // Flush a full stage: field1 is kept and everything else is cleared.
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = P; cyc();
    id[1] = 128'h5; cyc();
    iv[1] = 1'b0;
    chk("pre-flush occ", DW'(oc1), 2);
    fl[1] = 1'b1;
    #1 chk("flush in_ready", DW'(rdy1), '0);
    cyc();
    fl[1] = 1'b0;
    chk("flush out_valid", DW'(ov1), '0);
    chk("flush occ", DW'(oc1), '0);
    chk("flush data", od1, {64'h0, 32'h0000_1008, 32'h0});
    ordy[1] = 1'b1; cyc();
    chk("skid dropped", DW'(ov1), '0);

    // A beat presented during flush is refused and then taken on the next cycle.
    fl[1] = 1'b1; iv[1] = 1'b1; id[1] = C;
    #1 chk("flush+valid in_ready", DW'(rdy1), '0);
    cyc();
    chk("flush beat refused", DW'(ov1), '0);
    fl[1] = 1'b0; cyc();
    chk("held beat accepted", DW'(ov1), 1);
    chk("held beat data", od1, C);
    iv[1] = 1'b0; cyc();

    // Reset asserted mid-stream with two entries held.
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 128'hD; cyc();
    id[1] = 128'hE; cyc();
    iv[1] = 1'b0;
    chk("pre-reset occ", DW'(oc1), 2);
    #2 reset = 1'b0;
    #1;
    chk("async rst out_valid", DW'(ov1), '0);
    chk("async rst occ", DW'(oc1), '0);
    chk("async rst data", od1, '0);
    chk("async rst in_ready", DW'(rdy1), '0);
    cyc();
    reset = 1'b1;
    #1 chk("re-release in_ready", DW'(rdy1), 1);

    // Single-entry stage: ready follows out_ready when the stage is full.
    ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 128'h77; cyc();
    iv[0] = 1'b0;
    chk("s0 full valid", DW'(ov0), 1);
    chk("s0 full in_ready", DW'(rdy0), '0);
    chk("s0 full occ", DW'(oc0), 1);
    ordy[0] = 1'b1;
    #1 chk("s0 ready via out_ready", DW'(rdy0), 1);
    cyc();
    chk("s0 drained", DW'(ov0), '0);

    // Random traffic on both stages against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        ordy[k] = 1'($urandom_range(0, 1));
        fl[k]   = ($urandom_range(0, 19) == 0);
        id[k]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      cyc();
    end
    iv = '0; fl = '0;
    repeat (3) cyc();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
